// File: rtl/aud_pkg.sv
// Shared constants and helpers for the multi-channel Pokey audio control block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: ctrl bit positions, channel-data field offsets as functions of the
// volume width, and a clamping adder used by the mixer.
package aud_pkg;

  // Bit positions inside the 3-bit ctrl field
  localparam int GATE_OFF = 2;  // 0: gate the timer with poly5, 1: no gate
  localparam int SEL_P4   = 1;  // 1: noise from poly4, 0: noise from polyN
  localparam int PURE     = 0;  // 1: square tone, 0: noise

  // Channel write data layout, MSB first: ctrl[2:0], volOnly, vol[vol_w-1:0]
  function automatic int data_w(input int vol_w);
    return vol_w + 4;
  endfunction

  function automatic int ctrl_lsb(input int vol_w);
    return vol_w + 1;
  endfunction

  function automatic int volonly_bit(input int vol_w);
    return vol_w;
  endfunction

  // a + b, clamped to lim. The 33-bit intermediate keeps the carry so the
  // clamp is correct even when the raw sum wraps.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, lim}) return lim;
    return s[31:0];
  endfunction

endpackage

// File: rtl/aud_control_multi_if.sv
// Bundles the control, noise, timer and output signals of aud_control_multi.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level/pulse qualified by enn.
//
// master: the Pokey core side (drives writes, timers, noise bits; reads AUD/mix)
// slave : aud_control_multi itself
interface aud_control_multi_if #(
  parameter int NUM_CH = 4,
  parameter int VOL_W  = 4,
  parameter int MIX_W  = VOL_W + 3
);
  logic                      enn;
  logic                      wrEn;
  logic [2:0]                wrAddr;
  logic [VOL_W+3:0]          D;
  logic                      hpfWr;
  logic [NUM_CH-1:0]         hpfD;
  logic                      poly4In;
  logic                      poly5In;
  logic                      polyNIn;
  logic [NUM_CH-1:0]         Timer;
  logic [NUM_CH-1:0]         rstAudPhase;
  logic [NUM_CH*VOL_W-1:0]   AUD;
  logic [MIX_W-1:0]          mix;

  modport master (
    output enn, wrEn, wrAddr, D, hpfWr, hpfD,
    output poly4In, poly5In, polyNIn, Timer, rstAudPhase,
    input  AUD, mix
  );

  modport slave (
    input  enn, wrEn, wrAddr, D, hpfWr, hpfD,
    input  poly4In, poly5In, polyNIn, Timer, rstAudPhase,
    output AUD, mix
  );
endinterface

// File: rtl/aud_channel.sv
// One audio channel: ctrl/volume register, tone/noise level flop, high-pass flop.
// Latency: AUD follows the level/volume registers combinationally (0 cycles after the edge).
// Backpressure: none; every input is sampled on the falling edge when enn is high.
//
// Ports: clk/rstn, enn (clock enable), wr/d (register write), hpf_en/hpf_clr
// (filter enable and clear), timer (own divider pulse), pair_timer (partner's
// pulse that clocks the filter), phase_rst, poly4/poly5/polyn, aud (output lane).
module aud_channel
  import aud_pkg::*;
#(
  parameter int VOL_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enn,
  input  logic             wr,
  input  logic [VOL_W+3:0] d,
  input  logic             hpf_en,
  input  logic             hpf_clr,
  input  logic             timer,
  input  logic             pair_timer,
  input  logic             phase_rst,
  input  logic             poly4,
  input  logic             poly5,
  input  logic             polyn,
  output logic [VOL_W-1:0] aud
);

  localparam int CTRL_LSB = ctrl_lsb(VOL_W);
  localparam int VO_BIT   = volonly_bit(VOL_W);

  logic [2:0]       ctrl;
  logic             vol_only;
  logic [VOL_W-1:0] vol;
  logic             lvl;
  logic             hpf;

  logic gate;
  logic nxt_lvl;
  logic eff;

  assign gate    = ctrl[GATE_OFF] | poly5;
  assign nxt_lvl = ctrl[PURE] ? ~lvl : (ctrl[SEL_P4] ? poly4 : polyn);

  // Timer update reads the ctrl value held before this edge, so a write in the
  // same cycle only takes effect from the next pulse. hpf samples the pre-edge
  // lvl, which gives old^new when a channel filters against its own timer.
  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl     <= '0;
      vol_only <= 1'b0;
      vol      <= '0;
      lvl      <= 1'b0;
      hpf      <= 1'b0;
    end else if (enn) begin
      if (wr) begin
        ctrl     <= d[CTRL_LSB +: 3];
        vol_only <= d[VO_BIT];
        vol      <= d[VOL_W-1:0];
      end
      if (phase_rst) begin
        lvl <= 1'b0;
        hpf <= 1'b0;
      end else begin
        if (timer && gate) lvl <= nxt_lvl;
        if (hpf_clr)         hpf <= 1'b0;
        else if (pair_timer) hpf <= lvl;
      end
    end
  end

  assign eff = hpf_en ? (lvl ^ hpf) : lvl;
  assign aud = (vol_only | eff) ? vol : '0;

endmodule

// File: rtl/aud_control_multi.sv
// NUM_CH-channel Pokey audio control with per-channel high-pass and a saturating mixer.
// Latency: AUD changes right after the falling edge; mix is registered one edge later.
// Backpressure: none; enn low freezes all state (timers, writes, phase resets ignored).
//
// Ports: clk (state on falling edge), rstn (async active-low), bus (slave
// modport: writes, HPF enables, noise bits, Timer/rstAudPhase in; AUD/mix out).
// HPF_PAIR holds a 4-bit partner channel index per channel; an out-of-range
// index leaves that channel's filter flop unclocked. MIX_W must be 1..31.
module aud_control_multi
  import aud_pkg::*;
#(
  parameter int          NUM_CH   = 4,
  parameter int          VOL_W    = 4,
  parameter logic [31:0] HPF_PAIR = 32'h0000_0002,
  parameter int          MIX_W    = VOL_W + 3
) (
  input  logic                clk,
  input  logic                rstn,
  aud_control_multi_if.slave  bus
);

  localparam logic [31:0] MIX_MAX = (32'd1 << MIX_W) - 32'd1;

  logic [NUM_CH-1:0]       hpf_en;
  logic [NUM_CH-1:0]       hpf_clr;
  logic [NUM_CH*VOL_W-1:0] aud_w;
  logic [MIX_W-1:0]        mix_q;
  logic [31:0]             sum;

  // A write of 0 to an enable bit also flushes that channel's filter flop,
  // so re-enabling later starts from a clean state.
  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn)                       hpf_en <= '0;
    else if (bus.enn && bus.hpfWr)   hpf_en <= bus.hpfD;
  end

  assign hpf_clr = (bus.enn && bus.hpfWr) ? ~bus.hpfD : '0;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam int PAIR = int'(HPF_PAIR[4*i +: 4]);

    logic pair_timer;
    logic wr;

    if (PAIR < NUM_CH) begin : g_pair
      assign pair_timer = bus.Timer[PAIR];
    end else begin : g_nopair
      assign pair_timer = 1'b0;
    end

    // wrAddr values at or above NUM_CH never match a channel
    assign wr = bus.wrEn && (int'(bus.wrAddr) == i);

    aud_channel #(.VOL_W(VOL_W)) u_ch (
      .clk        (clk),
      .rstn       (rstn),
      .enn        (bus.enn),
      .wr         (wr),
      .d          (bus.D),
      .hpf_en     (hpf_en[i]),
      .hpf_clr    (hpf_clr[i]),
      .timer      (bus.Timer[i]),
      .pair_timer (pair_timer),
      .phase_rst  (bus.rstAudPhase[i]),
      .poly4      (bus.poly4In),
      .poly5      (bus.poly5In),
      .polyn      (bus.polyNIn),
      .aud        (aud_w[i*VOL_W +: VOL_W])
    );
  end

  // Clamping at every step is equivalent to clamping the final total because
  // all lanes are non-negative.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = sat_add(sum, 32'(aud_w[i*VOL_W +: VOL_W]), MIX_MAX);
    end
  end

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn)        mix_q <= '0;
    else if (bus.enn) mix_q <= MIX_W'(sum);
  end

  assign bus.AUD = aud_w;
  assign bus.mix = mix_q;

endmodule
